// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
// ALU control encodings and the default word width.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_ctrl_t;

  function automatic logic uses_adder(
    input logic [2:0] ctrl
  );
    return (ctrl == ALU_ADD) ||
           (ctrl == ALU_SUB) ||
           (ctrl == ALU_SLT);
  endfunction

endpackage

// File: rtl/mips_alu_adder.sv
// WIDTH-bit adder with carry-in.
// Produces sum, carry-out and signed overflow.
module mips_alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a}
              + {1'b0, b}
              + {{WIDTH{1'b0}}, cin};

  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH];

  // Same-sign operands whose sum flips sign.
  assign overflow =
    (a[WIDTH-1] == b[WIDTH-1]) &&
    (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/mips_alu.sv
// Single-cycle MIPS ALU with combinational outputs
// and a one-cycle registered copy of result and flags.
module mips_alu
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic [1:0]       flags_q
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;
  logic             add_c;
  logic             add_v;
  logic             lt;

  assign bb = control[2] ? ~srcb : srcb;

  mips_alu_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a       (srca),
    .b       (bb),
    .cin     (control[2]),
    .sum     (sum),
    .carry   (add_c),
    .overflow(add_v)
  );

  // With bb = ~srcb and cin = 1 the adder's
  // overflow is exactly the subtract overflow.
  assign lt = sum[WIDTH-1] ^ add_v;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      ALU_AND,
      ALU_ANDN: result = srca & bb;
      ALU_OR,
      ALU_ORN:  result = srca | bb;
      ALU_ADD: begin
        result   = sum;
        overflow = add_v;
      end
      ALU_SUB: begin
        result   = sum;
        overflow = add_v;
      end
      ALU_SLT:
        result = {{(WIDTH-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign carry = uses_adder(control) & add_c;
  assign zero  = ~|result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      flags_q  <= 2'b00;
    end else begin
      result_q <= result;
      zero_q   <= zero;
      flags_q  <= {carry, overflow};
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Randomized self-checking bench for mips_alu
// against a plain-arithmetic reference model.
module tb_mips_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [2:0]  control;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic [31:0] result_q;
  logic        zero_q;
  logic [1:0]  flags_q;

  int n_vec;
  int n_err;

  mips_alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .srca    (srca),
    .srcb    (srcb),
    .control (control),
    .result  (result),
    .zero    (zero),
    .carry   (carry),
    .overflow(overflow),
    .result_q(result_q),
    .zero_q  (zero_q),
    .flags_q (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic void ref_alu(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  c,
    output logic [31:0] r,
    output logic        cy,
    output logic        ov
  );
    longint sa;
    longint sb;
    longint sd;
    longint unsigned us;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    cy = 1'b0;
    ov = 1'b0;
    case (c)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd4: r = a & ~b;
      3'd5: r = a | ~b;
      3'd2: begin
        us = longint'(a) + longint'(b);
        r  = us[31:0];
        cy = us[32];
        sd = sa + sb;
        ov = (sd > 64'sd2147483647) ||
             (sd < -64'sd2147483648);
      end
      3'd6: begin
        r  = a - b;
        cy = (a >= b);
        sd = sa - sb;
        ov = (sd > 64'sd2147483647) ||
             (sd < -64'sd2147483648);
      end
      3'd7: begin
        r  = (sa < sb) ? 32'd1 : 32'd0;
        cy = (a >= b);
      end
      default: r = '0;
    endcase
  endfunction

  task automatic apply(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  c
  );
    logic [31:0] r;
    logic        cy;
    logic        ov;
    ref_alu(a, b, c, r, cy, ov);
    @(negedge clk);
    srca    = a;
    srcb    = b;
    control = c;
    #1;
    chk("result",   result,          r);
    chk("zero",     {31'd0, zero},   {31'd0, r == 0});
    chk("carry",    {31'd0, carry},  {31'd0, cy});
    chk("overflow", {31'd0, overflow}, {31'd0, ov});
    @(posedge clk);
    #1;
    chk("result_q", result_q,          r);
    chk("zero_q",   {31'd0, zero_q},   {31'd0, r == 0});
    chk("flags_q",  {30'd0, flags_q},  {30'd0, cy, ov});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    srca    = '0;
    srcb    = '0;
    control = '0;
    #12;
    chk("rst_result_q", result_q, 32'd0);
    chk("rst_zero_q", {31'd0, zero_q}, 32'd1);
    chk("rst_flags_q", {30'd0, flags_q}, 32'd0);
    #6 rst_n = 1'b1;

    apply(32'h1111_1111, 32'h0000_000F, 3'b000);
    apply(32'h1111_1111, 32'h0000_000F, 3'b001);
    apply(32'h1111_1111, 32'h0000_000F, 3'b010);
    apply(32'h1111_1111, 32'h0000_000F, 3'b110);
    apply(32'h0000_0001, 32'h0000_0002, 3'b111);
    apply(32'h0000_0002, 32'h0000_0001, 3'b111);
    apply(32'h8000_0000, 32'h0000_0000, 3'b111);
    apply(32'h0000_0001, 32'h0000_0001, 3'b110);
    apply(32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
    apply(32'hFFFF_FFFF, 32'h0000_0001, 3'b010);
    apply(32'h0000_0000, 32'h0000_0001, 3'b110);
    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100);
    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101);
    apply(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011);
    apply(32'h8000_0000, 32'h0000_0001, 3'b110);

    // Async reset between edges with a nonzero value held.
    apply(32'h1234_5678, 32'h0000_0001, 3'b010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_result_q", result_q, 32'd0);
    chk("arst_zero_q", {31'd0, zero_q}, 32'd1);
    chk("arst_flags_q", {30'd0, flags_q}, 32'd0);
    chk("arst_comb", result, 32'h1234_5679);
    #2 rst_n = 1'b1;
    #1;
    chk("rel_result_q", result_q, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_load", result_q, 32'h1234_5679);

    for (int i = 0; i < 400; i++)
      apply(pick(), pick(), 3'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
